// File: rtl/mem_1rw_ctrl_pkg.sv
// Shared definitions for the single-port memory controller:
// grant encoding and a constant clog2 used for pointer and credit widths.
package mem_1rw_pkg;

    localparam logic GNT_WR = 1'b0;
    localparam logic GNT_RD = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_1rw_ctrl_rsp_fifo.sv
// First-word-fall-through response FIFO; the head entry is visible while not empty.
// Storage is not reset: only pointers and occupancy define the FIFO state.
module mem_1rw_ctrl_rsp_fifo
    import mem_1rw_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        do_pop   = pop && !empty;
        wr_ptr_d = push   ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
        // Drive zero rather than a stale slot when nothing is held.
        dout     = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mem_1rw_ctrl.sv
// Single-port memory client: round-robin write/read arbitration onto one port,
// fixed-latency read tracking and a credit-protected in-order response FIFO.
module mem_1rw_ctrl
    import mem_1rw_pkg::*;
#(
    parameter int WIDTH_ADDR = 8,
    parameter int WIDTH_DATA = 8,
    parameter int RD_LATENCY = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [WIDTH_ADDR-1:0] wr_req_addr,
    input  logic [WIDTH_DATA-1:0] wr_req_data,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [WIDTH_ADDR-1:0] rd_req_addr,
    output logic                  rd_rsp_valid,
    input  logic                  rd_rsp_ready,
    output logic [WIDTH_DATA-1:0] rd_rsp_data,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic [WIDTH_ADDR-1:0] mem_addr,
    output logic [WIDTH_DATA-1:0] mem_din,
    input  logic [WIDTH_DATA-1:0] mem_dout
);

    localparam int CW = clog2(RSP_DEPTH) + 1;

    if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_rd_latency
        $error("mem_1rw_ctrl: RD_LATENCY must be 1 or 2");
    end
    if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_rsp_depth
        $error("mem_1rw_ctrl: RSP_DEPTH must be a power of 2, at least 2");
    end

    logic                  last_grant_q, last_grant_d;
    logic [CW-1:0]         credit_q, credit_d;
    logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic                  rd_elig;
    logic                  grant_wr, grant_rd;
    logic                  rsp_push, rsp_pop;
    logic                  fifo_empty, fifo_full;

    // Grants are held off while reset is asserted so every output is 0 during reset.
    always_comb begin
        rd_elig  = rd_req_valid && (credit_q < CW'(RSP_DEPTH));
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (rst_n) begin
            if (wr_req_valid && rd_elig) begin
                grant_wr = (last_grant_q == GNT_RD);
                grant_rd = (last_grant_q == GNT_WR);
            end else begin
                grant_wr = wr_req_valid;
                grant_rd = rd_elig;
            end
        end
        last_grant_d = grant_wr ? GNT_WR : (grant_rd ? GNT_RD : last_grant_q);
    end

    always_comb begin
        wr_req_ready = grant_wr;
        rd_req_ready = grant_rd;
        mem_wen      = grant_wr;
        mem_ren      = grant_rd;
        mem_addr     = '0;
        mem_din      = '0;
        if (grant_wr) begin
            mem_addr = wr_req_addr;
            mem_din  = wr_req_data;
        end else if (grant_rd) begin
            mem_addr = rd_req_addr;
        end
    end

    // Bit RD_LATENCY-1 marks the cycle in which mem_dout carries the issued read.
    always_comb begin
        rd_pipe_d    = (rd_pipe_q << 1) | RD_LATENCY'(grant_rd);
        rsp_push     = rd_pipe_q[RD_LATENCY-1];
        rd_rsp_valid = !fifo_empty;
        rsp_pop      = rd_rsp_valid && rd_rsp_ready;
        credit_d     = credit_q;
        if (grant_rd && !rsp_pop) begin
            credit_d = credit_q + CW'(1);
        end else if (!grant_rd && rsp_pop) begin
            credit_d = credit_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GNT_RD;
            credit_q     <= '0;
            rd_pipe_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            credit_q     <= credit_d;
            rd_pipe_q    <= rd_pipe_d;
        end
    end

    mem_1rw_ctrl_rsp_fifo #(
        .WIDTH (WIDTH_DATA),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_push),
        .din   (mem_dout),
        .pop   (rsp_pop),
        .dout  (rd_rsp_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_push |-> !fifo_full);
    a_one_mem_op: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_wen && mem_ren));
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        credit_q <= CW'(RSP_DEPTH));

endmodule
